// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access sizes, direction and FSM states.
package mem_pkg;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte offset 0 lives in bits [31:24] of a RAM word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  dataType,
    input  logic [31:0] dataIn,
    input  logic [31:0] rdWord,
    output logic [3:0]  wrEn,
    output logic [31:0] wrData,
    output logic [31:0] rdData
);

    logic [31:0] byteShifted;

    always_comb begin
        wrEn        = 4'b1111;
        wrData      = dataIn;
        rdData      = rdWord;
        byteShifted = rdWord >> {~offset, 3'b000};
        case (dataType)
            DT_BYTE: begin
                wrEn   = 4'b1000 >> offset;
                wrData = {4{dataIn[7:0]}};
                rdData = {24'h0, byteShifted[7:0]};
            end
            // halfwords ignore offset[0], so only offset[1] picks the upper or lower half
            DT_HALF: begin
                wrEn   = offset[1] ? 4'b0011 : 4'b1100;
                wrData = {2{dataIn[15:0]}};
                rdData = {16'h0, (offset[1] ? rdWord[15:0] : rdWord[31:16])};
            end
            default: begin
                wrEn   = 4'b1111;
                wrData = dataIn;
                rdData = rdWord;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory side of the MAR/MDR handshake: captures a request, waits LATENCY cycles,
// performs one access on a big-endian byte RAM and holds mfc until memEn drops.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        memEn,
    input  logic        memRW,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    input  logic [1:0]  dataType,
    output logic [31:0] dataOut,
    output logic        mfc,
    output logic        busy
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    state_t      state, stateNext;
    logic [3:0]  count, countNext;
    logic        mfcNext, busyNext;
    logic [31:0] dataNext;
    logic        capture, doAccess;

    logic [ADDR_W-1:0] capAddr;
    logic              capRW;
    logic [31:0]       capData;
    logic [1:0]        capType;

    logic [31:0]       ram [DEPTH];
    logic [ADDR_W-3:0] wordIdx;
    logic [31:0]       rdWord, rdData, wrData;
    logic [3:0]        wrEn;
    logic              unusedAddr;

    assign unusedAddr = ^address[31:ADDR_W];
    assign wordIdx    = capAddr[ADDR_W-1:2];
    assign rdWord     = ram[wordIdx];

    mem_lane_align u_align (
        .offset   (capAddr[1:0]),
        .dataType (capType),
        .dataIn   (capData),
        .rdWord   (rdWord),
        .wrEn     (wrEn),
        .wrData   (wrData),
        .rdData   (rdData)
    );

    always_comb begin
        stateNext = state;
        countNext = count;
        mfcNext   = mfc;
        busyNext  = busy;
        dataNext  = dataOut;
        capture   = 1'b0;
        doAccess  = 1'b0;
        case (state)
            S_IDLE: begin
                if (memEn) begin
                    capture   = 1'b1;
                    countNext = LAT_LOAD;
                    busyNext  = 1'b1;
                    mfcNext   = 1'b0;
                    stateNext = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!memEn) begin
                    busyNext  = 1'b0;
                    mfcNext   = 1'b0;
                    stateNext = S_IDLE;
                end else if (count != 4'd0) begin
                    countNext = count - 4'd1;
                end else begin
                    doAccess  = 1'b1;
                    mfcNext   = 1'b1;
                    stateNext = S_DONE;
                    if (capRW == RW_READ) begin
                        dataNext = rdData;
                    end
                end
            end
            S_DONE: begin
                if (!memEn) begin
                    mfcNext   = 1'b0;
                    busyNext  = 1'b0;
                    stateNext = S_IDLE;
                end
            end
            default: begin
                mfcNext   = 1'b0;
                busyNext  = 1'b0;
                stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            mfc     <= 1'b0;
            busy    <= 1'b0;
            dataOut <= 32'h0;
        end else begin
            state   <= stateNext;
            count   <= countNext;
            mfc     <= mfcNext;
            busy    <= busyNext;
            dataOut <= dataNext;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            capAddr <= '0;
            capRW   <= RW_READ;
            capData <= 32'h0;
            capType <= DT_WORD;
        end else if (capture) begin
            capAddr <= address[ADDR_W-1:0];
            capRW   <= memRW;
            capData <= dataIn;
            capType <= dataType;
        end
    end

    // RAM survives reset; the clr gate keeps a write from landing on the edge that aborts it
    always_ff @(posedge clk) begin
        if (!clr && doAccess && capRW == RW_WRITE) begin
            for (int i = 0; i < 4; i++) begin
                if (wrEn[i]) begin
                    ram[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, endianness, partial writes, hold, abort, reset.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clk;
    logic        clr;
    logic        memEn;
    logic        memRW;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [1:0]  dataType;
    logic [31:0] dataOut;
    logic        mfc;
    logic        busy;

    int nChecks = 0;
    int nFails  = 0;

    mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
        .clk      (clk),
        .clr      (clr),
        .memEn    (memEn),
        .memRW    (memRW),
        .address  (address),
        .dataIn   (dataIn),
        .dataType (dataType),
        .dataOut  (dataOut),
        .mfc      (mfc),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] dtype);
        memRW    = rw;
        address  = addr;
        dataIn   = data;
        dataType = dtype;
        memEn    = 1'b1;
    endtask

    // waits a bounded number of cycles; a timeout shows up as a failed mfc check
    task automatic waitMfc(input string tag);
        int n = 0;
        while (mfc !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, " mfc"}, {31'h0, mfc}, 32'h1);
    endtask

    task automatic finishReq(input string tag);
        memEn = 1'b0;
        tick();
        checkOutput({tag, " release"}, {30'h0, busy, mfc}, 32'h0);
    endtask

    task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] dtype);
        applyStimulus(RW_WRITE, addr, data, dtype);
        tick();
        waitMfc(tag);
        finishReq(tag);
    endtask

    task automatic doRead(input string tag, input logic [31:0] addr, input logic [1:0] dtype,
                          input logic [31:0] expected);
        applyStimulus(RW_READ, addr, 32'hA5A5A5A5, dtype);
        tick();
        waitMfc(tag);
        checkOutput({tag, " data"}, dataOut, expected);
        finishReq(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr      = 1'b1;
        memEn    = 1'b0;
        memRW    = RW_READ;
        address  = 32'h0;
        dataIn   = 32'h0;
        dataType = DT_WORD;
        tick();
        tick();
        clr = 1'b0;
        checkOutput("reset mfc", {31'h0, mfc}, 32'h0);
        checkOutput("reset busy", {31'h0, busy}, 32'h0);
        checkOutput("reset dataOut", dataOut, 32'h0);

        // exact latency: capture at E0, mfc first high after E0+2
        applyStimulus(RW_WRITE, 32'h04, 32'hDEADBEEF, DT_WORD);
        tick();
        checkOutput("lat E0 busy", {31'h0, busy}, 32'h1);
        checkOutput("lat E0 mfc", {31'h0, mfc}, 32'h0);
        tick();
        checkOutput("lat E1 mfc", {31'h0, mfc}, 32'h0);
        checkOutput("lat E1 busy", {31'h0, busy}, 32'h1);
        tick();
        checkOutput("lat E2 mfc", {31'h0, mfc}, 32'h1);
        checkOutput("lat E2 dataOut", dataOut, 32'h0);
        finishReq("lat");

        doRead("rd word 04", 32'h04, DT_WORD, 32'hDEADBEEF);
        doRead("rd byte 05", 32'h05, DT_BYTE, 32'h000000AD);
        doRead("rd half 07", 32'h07, DT_HALF, 32'h0000BEEF);
        doRead("rd byte 07", 32'h07, DT_BYTE, 32'h000000EF);
        doRead("rd wrap 104", 32'hFFFF_FF04, DT_WORD, 32'hDEADBEEF);
        doRead("rd type11", 32'h06, 2'b11, 32'hDEADBEEF);

        doWrite("wr half 06", 32'h06, 32'h00001234, DT_HALF);
        doRead("merge half", 32'h04, DT_WORD, 32'hDEAD1234);
        doWrite("wr byte 04", 32'h04, 32'h00000077, DT_BYTE);
        doRead("merge byte", 32'h04, DT_WORD, 32'h77AD1234);

        // long hold with inputs changing after capture
        doWrite("hold pre", 32'h10, 32'hAABBCCDD, DT_WORD);
        applyStimulus(RW_WRITE, 32'h10, 32'h00000001, DT_BYTE);
        tick();
        dataIn   = 32'h55555555;
        address  = 32'h14;
        dataType = DT_WORD;
        memRW    = RW_READ;
        waitMfc("hold");
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("hold mfc", {31'h0, mfc}, 32'h1);
            checkOutput("hold dataOut", dataOut, 32'h77AD1234);
        end
        finishReq("hold");
        doRead("hold result", 32'h10, DT_WORD, 32'h01BBCCDD);

        // abort one cycle after capture
        doWrite("abort pre", 32'h20, 32'h11223344, DT_WORD);
        applyStimulus(RW_WRITE, 32'h20, 32'hCAFEF00D, DT_WORD);
        tick();
        memEn = 1'b0;
        tick();
        checkOutput("abort idle", {30'h0, busy, mfc}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("abort mfc", {31'h0, mfc}, 32'h0);
        end
        doRead("abort result", 32'h20, DT_WORD, 32'h11223344);

        // reset lands on the edge that would have performed the write
        doWrite("rst pre", 32'h30, 32'h55667788, DT_WORD);
        applyStimulus(RW_WRITE, 32'h30, 32'hFFFFFFFF, DT_WORD);
        tick();
        tick();
        checkOutput("rst busy before", {30'h0, busy, mfc}, 32'h2);
        clr = 1'b1;
        tick();
        checkOutput("rst mfc", {31'h0, mfc}, 32'h0);
        checkOutput("rst busy", {31'h0, busy}, 32'h0);
        checkOutput("rst dataOut", dataOut, 32'h0);
        clr   = 1'b0;
        memEn = 1'b0;
        tick();
        checkOutput("rst idle", {30'h0, busy, mfc}, 32'h0);
        doRead("rst result 30", 32'h30, DT_WORD, 32'h55667788);
        doRead("rst keep 04", 32'h04, DT_WORD, 32'h77AD1234);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the control unit's memory handshake.
- Accepts requests qualified by memEn/memRW from the CPU control unit and performs byte, halfword or word reads and writes on an internal big-endian RAM.
- Signals completion on mfc after a fixed latency and holds it until the initiator drops memEn.
- Sits between the MAR/MDR datapath and the control unit; replaces the ideal single-cycle RAM model.

Parameters:
- ADDR_W, 8, byte-address bits used; RAM depth is 2**ADDR_W bytes.
- LATENCY, 2, cycles from request capture to mfc assertion; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous reset, active-high.
- memEn  in  1  request valid; held high by the initiator until it sees mfc.
- memRW  in  1  1 = read, 0 = write.
- address  in  32  byte address; only bits [ADDR_W-1:0] are used, upper bits ignored (wrap).
- dataIn  in  32  write data, right-justified for byte/halfword.
- dataType  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- dataOut  out  32  read data, zero-extended, right-justified.
- mfc  out  1  memory function complete.
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset (clr=1 at an edge): state IDLE, mfc=0, busy=0, dataOut=0, counter=0. RAM contents are NOT cleared.
- Reset has priority over every other event, including mid-BUSY and DONE. An aborted write never lands.
- All outputs are registered.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with memEn=1, capture address, memRW, dataIn and dataType.
  - Load counter = LATENCY-1 and go to BUSY; busy=1 after that edge.
- BUSY:
  - If memEn=0 at an edge: abort and go to IDLE. mfc stays 0, no write occurs, busy=0.
  - Else if counter≠0: decrement.
  - Else: perform the access, set mfc=1, go to DONE.
  - Net effect: if memEn is captured at edge E0, mfc is first high after edge E0+LATENCY.
- Access, using captured values only:
  - Byte order is big-endian: the byte at address A is the MSB of the word at A&~3.
  - Halfword accesses align by clearing bit 0; word accesses align by clearing bits [1:0].
  - A read loads dataOut at the same edge mfc rises.
  - A write updates the addressed bytes only, at the same edge mfc rises; dataOut is unchanged.
- DONE:
  - mfc=1 and dataOut stay stable while memEn=1. No repeat access: exactly one write per request.
  - On an edge with memEn=0: mfc=0, busy=0, go to IDLE.
  - A new request is capturable at the edge following the return to IDLE.
- Input changes after capture are ignored until the next IDLE capture.

Decomposition:
- Shared package mem_pkg:
  - dataType encodings DT_BYTE/DT_HALF/DT_WORD.
  - State encodings S_IDLE/S_BUSY/S_DONE.
  - RW_READ/RW_WRITE constants.
- One combinational sub-module, mem_lane_align:
  - Maps {aligned address, dataType, dataIn} to per-byte write enables and lane data.
  - Extracts and zero-extends read data.
- FSM, counter and RAM array live in mem_responder.

Test Plan:
- Latency check: LATENCY=2, reset, hold memEn=1 memRW=0 word 0xDEADBEEF @0x04 captured at edge E0 -> mfc=0 after E0+1, mfc=1 after E0+2, busy=1 from E0+1. Drop memEn -> mfc=0, busy=0 next edge.
- Read-back and endianness: word read @0x04 -> dataOut 0xDEADBEEF. Byte read @0x05 -> 0x000000AD. Halfword read @0x07 (aligns to 0x06) -> 0x0000BEEF.
- Partial write merge: halfword write 0x00001234 @0x06, then word read @0x04 -> 0xDEAD1234. Byte write 0x77 @0x04, then word read @0x04 -> 0x77AD1234.
- Long hold: keep memEn=1 for 5 cycles after mfc on a byte write of 0x01 @0x10 -> mfc stays 1, dataOut stable, byte @0x10 =0x01, no extra writes.
- Abort: write 0xCAFEF00D @0x20, drop memEn one cycle after capture -> mfc never 1, busy=0 next edge, later word read @0x20 returns the prior contents.
- Reset mid-op: assert clr while in BUSY on a write @0x30 -> next edge IDLE, mfc=0, dataOut=0, @0x30 unchanged. Word @0x04 still 0x77AD1234, since RAM is not cleared.
